fsk_dds_wave_send: RTL

- Parametrised successor to the fixed-step ROM-address DA sender. Generates ROM addresses from a phase accumulator (DDS), so output frequency is set by a tuning word rather than a divider.
- Supports 2-FSK via two tuning words selected by a data bit, scales amplitude about DAC midscale, and accepts runtime tuning-word updates through a valid/ready handshake.
- Sits between the wave ROM (1-cycle read latency) and the parallel DA chip.

---
 rtl/fsk_dds_wave_send.sv | 97 +++++++++
 1 files changed

// File: rtl/fsk_dds_wave_send.sv
// DDS wave sender: phase accumulator drives the wave ROM address, 2-FSK tuning-word
// select, runtime tuning-word update committed on wrap, and amplitude scaling about midscale.
module fsk_dds_wave_send #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter logic [ACC_W-1:0] FWORD0_INIT = 32'h0100_0000,
  parameter logic [ACC_W-1:0] FWORD1_INIT = 32'h0200_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fsk_bit,
  input  logic [7:0]        amp,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ACC_W-1:0]  cfg_fword0,
  input  logic [ACC_W-1:0]  cfg_fword1,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wrap,
  output logic              da_clk,
  output logic [DATA_W-1:0] da_data
);

  localparam int S_W = DATA_W + 1;
  localparam int P_W = S_W + 9;
  localparam logic [S_W-1:0]        MID_S = S_W'(2 ** (DATA_W - 1));
  localparam logic signed [P_W-1:0] MID_P = P_W'(2 ** (DATA_W - 1));
  localparam logic signed [P_W-1:0] MAX_P = P_W'(2 ** DATA_W - 1);
  localparam logic [DATA_W-1:0]     MID_D = DATA_W'(2 ** (DATA_W - 1));

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] fword0, fword1;
  logic [ACC_W-1:0] shadow0, shadow1;
  logic             pending;
  logic [ACC_W-1:0] fword_sel;
  logic [ACC_W:0]   sum;

  logic signed [S_W-1:0] s;
  logic signed [P_W-1:0] s_ext, a_ext, p, q, r;
  logic [DATA_W-1:0]     sat;

  assign fword_sel = fsk_bit ? fword1 : fword0;
  assign sum       = {1'b0, acc} + {1'b0, fword_sel};
  assign rd_addr   = acc[ACC_W-1 -: ADDR_W];
  assign cfg_ready = ~pending;
  assign da_clk    = ~clk;

  // Offset-binary to signed, gain, then back to offset-binary with clamping.
  assign s     = $signed({1'b0, rd_data} - MID_S);
  assign s_ext = P_W'(s);
  assign a_ext = P_W'($signed({1'b0, amp}));
  assign p     = s_ext * a_ext;
  assign q     = p >>> 8;
  assign r     = q + MID_P;

  always_comb begin
    sat = r[DATA_W-1:0];
    if (r < 0)
      sat = '0;
    else if (r > MAX_P)
      sat = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      wrap    <= 1'b0;
      da_data <= MID_D;
      fword0  <= FWORD0_INIT;
      fword1  <= FWORD1_INIT;
      shadow0 <= '0;
      shadow1 <= '0;
      pending <= 1'b0;
    end else begin
      if (en) begin
        acc  <= sum[ACC_W-1:0];
        wrap <= sum[ACC_W];
      end else begin
        wrap <= 1'b0;
      end
      // Commit only at a wrap so the new step starts at a period boundary.
      if (wrap && pending) begin
        fword0  <= shadow0;
        fword1  <= shadow1;
        pending <= 1'b0;
      end else if (cfg_valid && !pending) begin
        shadow0 <= cfg_fword0;
        shadow1 <= cfg_fword1;
        pending <= 1'b1;
      end
      da_data <= sat;
    end
  end

endmodule
